// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte loader.
// Contents: FSM state enum, word/byte widths, byte lanes per word.
package imem_loader_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANES  = WORD_W / BYTE_W;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    WRITE,
    CHECK
  } state_e;

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian byte-lane assembler: packs incoming bytes into a 32-bit word.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   i_clr        - restart at lane 0 with an empty word
//   i_shift      - place i_din into the current lane and advance
//   i_din        - byte to place
//   o_byte_idx   - lane the next byte lands in (0..3)
//   o_word       - assembled word register
//   o_word_full  - one-cycle pulse in the cycle after the 4th byte lands
module loader_word_asm
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_shift,
  input  logic [BYTE_W-1:0] i_din,
  output logic [1:0]        o_byte_idx,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_full
);

  logic [1:0]        r_byte_idx;
  logic [WORD_W-1:0] r_word;
  logic              r_word_full;

  // Lane register, word register and full pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_byte_idx  <= 2'd0;
      r_word      <= '0;
      r_word_full <= 1'b0;
    end else begin
      r_word_full <= 1'b0;
      if (i_clr) begin
        r_byte_idx <= 2'd0;
        r_word     <= '0;
      end else if (i_shift) begin
        r_word[BYTE_W*r_byte_idx +: BYTE_W] <= i_din;
        r_byte_idx  <= r_byte_idx + 2'd1;
        r_word_full <= (r_byte_idx == 2'(LANES - 1));
      end
    end
  end

  assign o_byte_idx  = r_byte_idx;
  assign o_word      = r_word;
  assign o_word_full = r_word_full;

endmodule

// File: rtl/imem_byte_loader.sv
// Framed byte-stream program loader for the core's instruction memory.
// Frame: HDR_BYTE, word count N, 4*N payload bytes (LSB first), checksum.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (XOR checksum byte and
// CHECK state; when undefined no checksum byte is expected, load_err is 0).
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   rx_data/valid/ready    - byte input handshake (transfer on valid&&ready)
//   imem_we/addr/wdata     - one-cycle instruction-memory write port
//   cpu_hold               - holds the core in reset until a frame completes
//   load_done, load_err    - sticky status of the last frame
module imem_byte_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned START_ADDR = 0,
  parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  state_e            r_state;
  logic              r_rx_ready;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [7:0]        r_remaining;
  logic              r_cpu_hold;
  logic              r_load_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
  logic              r_load_err;
`endif

  logic              w_accept;
  logic [1:0]        w_byte_idx;
  logic [WORD_W-1:0] w_word;
  logic              w_word_full;

  assign w_accept = rx_valid && r_rx_ready;

  // Payload bytes go to the lane assembler; COUNT restarts it at lane 0
  loader_word_asm u_word_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_accept && (r_state == COUNT)),
    .i_shift     (w_accept && (r_state == DATA)),
    .i_din       (rx_data),
    .o_byte_idx  (w_byte_idx),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  // Frame FSM with address counter, word countdown and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rx_ready  <= 1'b1;
      r_imem_addr <= ADDR_W'(START_ADDR);
      r_remaining <= 8'd0;
      r_cpu_hold  <= 1'b1;
      r_load_done <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum      <= 8'd0;
      r_load_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && (rx_data == HDR_BYTE)) begin
            r_state     <= COUNT;
            r_load_done <= 1'b0;
            r_cpu_hold  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_load_err  <= 1'b0;
`endif
          end
        end
        COUNT: begin
          if (w_accept) begin
            r_remaining <= rx_data;
            r_imem_addr <= ADDR_W'(START_ADDR);
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
            if (rx_data == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state     <= CHECK;
`else
              r_state     <= IDLE;
              r_load_done <= 1'b1;
              r_cpu_hold  <= 1'b0;
`endif
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ rx_data;
`endif
            // Last lane: the word register is complete on the next cycle
            if (w_byte_idx == 2'(LANES - 1)) begin
              r_state    <= WRITE;
              r_rx_ready <= 1'b0;
            end
          end
        end
        WRITE: begin
          r_rx_ready  <= 1'b1;
          r_imem_addr <= r_imem_addr + ADDR_W'(1);
          r_remaining <= r_remaining - 8'd1;
          if (r_remaining == 8'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state     <= CHECK;
`else
            r_state     <= IDLE;
            r_load_done <= 1'b1;
            r_cpu_hold  <= 1'b0;
`endif
          end else begin
            r_state <= DATA;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (w_accept) begin
            r_state <= IDLE;
            if (rx_data == r_csum) begin
              r_load_done <= 1'b1;
              r_cpu_hold  <= 1'b0;
            end else begin
              r_load_err  <= 1'b1;
            end
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_ready   = r_rx_ready;
  assign imem_we    = w_word_full;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = w_word;
  assign cpu_hold   = r_cpu_hold;
  assign load_done  = r_load_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign load_err   = r_load_err;
`else
  assign load_err   = 1'b0;
`endif

endmodule

// File: doc/imem_byte_loader.md
# imem_byte_loader

Byte-stream program loader feeding the pipeline core's instruction memory. Receives framed bytes from the dedicated inputs, assembles little-endian 32-bit instruction words, writes them sequentially into instruction memory, and holds the core in reset until a frame completes. This is the input-direction counterpart to the core's observation outputs: the host uses it to load a program, then watches PC and data-memory activity on the outputs.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width.
- `START_ADDR`, 0: word address of the first written word.
- `HDR_BYTE`, 8'hA5: frame-start byte.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `rx_data` input 8: byte from the host, taken from the dedicated inputs.
- `rx_valid` input 1: `rx_data` is valid this cycle.
- `rx_ready` output 1: loader accepts a byte this cycle.
- `imem_we` output 1: one-cycle instruction-memory write strobe.
- `imem_addr` output ADDR_W: write word address.
- `imem_wdata` output 32: write data.
- `cpu_hold` output 1: active-high reset request to the pipeline core.
- `load_done` output 1: sticky; the last frame completed successfully.
- `load_err` output 1: sticky; the last frame failed its checksum.

## Operation
- A byte transfers when `rx_valid && rx_ready`. `rx_ready` is 1 in every state except WRITE.
- Frame format: `HDR_BYTE`, then count N (0..255 words), then 4·N payload bytes (LSB first per word), then one checksum byte.
- FSM states:
  - IDLE: waits for a byte. Non-header bytes are dropped. A header byte goes to COUNT, clears `load_done` and `load_err`, and sets `cpu_hold`.
  - COUNT: captures N, loads `imem_addr` with `START_ADDR`, clears the checksum accumulator. If N=0, goes to CHECK; otherwise goes to DATA.
  - DATA: shifts each byte into the word register at byte lane `byte_idx` (0..3) and XORs it into the accumulator. On the 4th byte, goes to WRITE.
  - WRITE: asserts `imem_we` for exactly one cycle with the assembled word and decrements the remaining count. Next state is DATA if words remain, otherwise CHECK. After the write, `imem_addr` increments.
  - CHECK: receives the checksum byte. A match sets `load_done` and clears `cpu_hold`. A mismatch sets `load_err` and keeps `cpu_hold`=1. Returns to IDLE.
- Address wraps modulo 2^ADDR_W; no error is flagged on wrap.
- A header byte arriving mid-frame is treated as payload, not as a restart. Only `rst_n` aborts a frame.
- Reset values: `rx_ready`=1, `imem_we`=0, `imem_addr`=`START_ADDR`, `imem_wdata`=0, `cpu_hold`=1, `load_done`=0, `load_err`=0, state IDLE.

## Timing
- Outputs are registered.
- `imem_we` rises in the cycle after the 4th byte of a word is accepted; `imem_addr` and `imem_wdata` are stable in that cycle.
- Peak throughput is 4 bytes per 5 cycles.
- `cpu_hold` falls, and `load_done` rises, in the cycle after a valid checksum is accepted.
- Reset asserted mid-frame: the next edge forces the reset values. Partial words are discarded and no write occurs.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: the CHECK state and XOR accumulator behave as above.
- Not defined: no checksum byte is expected and the accumulator is not built. After the last WRITE, or directly from COUNT when N=0, the FSM sets `load_done`, clears `cpu_hold`, and returns to IDLE. `load_err` is tied to 0.

## Structure
- Package `imem_loader_pkg`: state enum (IDLE, COUNT, DATA, WRITE, CHECK) and the word-width constant 32.
- Sub-module `loader_word_asm`: a byte-lane assembler holding `byte_idx`, the 32-bit word register, and a `word_full` flag. The FSM, address counter, checksum, and status flags live in `imem_byte_loader`.

## Test plan
- Reset, then send A5, 01, 13, 00, 00, 00, chk=13 → one `imem_we` with addr 0 and data 0x00000013; `load_done`=1 and `cpu_hold`=0 on the next cycle.
- Send A5, 02, then 8 bytes with `rx_valid` toggling every other cycle, then a correct checksum → writes to addr 0 and 1 with correct words; exactly 2 write strobes.
- Send the same frame with a wrong checksum → both words written; `load_err`=1; `cpu_hold` stays 1.
- Send A5, 00, chk=00 → no writes; `load_done`=1. With the macro undefined, A5, 00 alone gives `load_done`=1.
- Pull `rst_n` low after 2 payload bytes → no write; all outputs return to reset values. A following full frame loads correctly starting at `START_ADDR`.
- With `ADDR_W`=2, load 5 words → the 5th write goes to addr 0 (wrap).
